mem_lsu: RTL and testbench



---
 rtl/mem_lsu.sv | 246 ++++++++++++++++++++++++
 tb/tb_mem_lsu.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// MEM pipeline stage: byte/half/word loads and stores over an ack-handshake data bus
// with a bounded wait, misalignment/timeout exceptions and registered MEM/WB outputs.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | accept an instruction; pass non-memory ops, trap misaligned
//   BUS   | request held on the bus; wait for ack or timeout
module mem_lsu #(
  parameter int ADDR_W    = 32,
  parameter int REGADDR_W = 5,
  parameter int ALUOP_W   = 8,
  parameter int TIMEOUT   = 255,
  parameter logic [ALUOP_W-1:0] EXE_LB_OP  = 8'b1110_0000,
  parameter logic [ALUOP_W-1:0] EXE_LH_OP  = 8'b1110_0001,
  parameter logic [ALUOP_W-1:0] EXE_LW_OP  = 8'b1110_0011,
  parameter logic [ALUOP_W-1:0] EXE_LBU_OP = 8'b1110_0100,
  parameter logic [ALUOP_W-1:0] EXE_LHU_OP = 8'b1110_0101,
  parameter logic [ALUOP_W-1:0] EXE_SB_OP  = 8'b1110_1000,
  parameter logic [ALUOP_W-1:0] EXE_SH_OP  = 8'b1110_1001,
  parameter logic [ALUOP_W-1:0] EXE_SW_OP  = 8'b1110_1011
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic                 flush_i,
  input  logic [REGADDR_W-1:0] wd_i,
  input  logic                 wreg_i,
  input  logic [31:0]          wdata_i,
  input  logic [ALUOP_W-1:0]   aluop_i,
  input  logic [ADDR_W-1:0]    mem_addr_i,
  input  logic [31:0]          reg2_i,
  output logic                 stall_req_o,
  output logic                 wb_valid_o,
  output logic [REGADDR_W-1:0] wd_o,
  output logic                 wreg_o,
  output logic [31:0]          wdata_o,
  output logic                 excp_o,
  output logic [1:0]           excp_code_o,
  output logic [ADDR_W-1:0]    badaddr_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic                 mem_we_o,
  output logic [3:0]           mem_sel_o,
  output logic [31:0]          mem_data_o,
  output logic                 mem_ce_o,
  input  logic [31:0]          mem_data_i,
  input  logic                 mem_ack_i
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;

  typedef enum logic {S_IDLE, S_BUS} state_t;
  state_t state, state_n;

  logic [CW-1:0]        cnt;
  logic                 flush_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [1:0]           sz_q;
  logic                 uns_q, st_q, wreg_q;
  logic [REGADDR_W-1:0] wd_q;

  logic       is_mem, is_st, uns, misal;
  logic [1:0] sz;
  logic [3:0] sel_c;
  logic [31:0] sdata_c, lane, load_data;
  logic stall_c, go_bus, pass_op, mis, done, tmo, kill;

  always_comb begin
    is_mem = 1'b1;
    is_st  = 1'b0;
    sz     = SZ_W;
    uns    = 1'b0;
    case (aluop_i)
      EXE_LB_OP:  sz = SZ_B;
      EXE_LBU_OP: begin sz = SZ_B; uns = 1'b1; end
      EXE_LH_OP:  sz = SZ_H;
      EXE_LHU_OP: begin sz = SZ_H; uns = 1'b1; end
      EXE_LW_OP:  sz = SZ_W;
      EXE_SB_OP:  begin sz = SZ_B; is_st = 1'b1; end
      EXE_SH_OP:  begin sz = SZ_H; is_st = 1'b1; end
      EXE_SW_OP:  begin sz = SZ_W; is_st = 1'b1; end
      default:    is_mem = 1'b0;
    endcase
  end

  always_comb begin
    misal   = ((sz == SZ_H) && mem_addr_i[0]) || ((sz == SZ_W) && (mem_addr_i[1:0] != 2'b00));
    sel_c   = 4'b1111;
    sdata_c = reg2_i;
    case (sz)
      SZ_B: begin
        sel_c   = 4'b0001 << mem_addr_i[1:0];
        sdata_c = {4{reg2_i[7:0]}};
      end
      SZ_H: begin
        sel_c   = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        sdata_c = {2{reg2_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend.
  always_comb begin
    lane      = mem_data_i >> {addr_q[1:0], 3'b000};
    load_data = mem_data_i;
    case (sz_q)
      SZ_B: load_data = uns_q ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      SZ_H: load_data = uns_q ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    stall_c = 1'b0;
    go_bus  = 1'b0;
    pass_op = 1'b0;
    mis     = 1'b0;
    done    = 1'b0;
    tmo     = 1'b0;
    case (state)
      S_IDLE: begin
        if (valid_i && !flush_i) begin
          if (!is_mem)    pass_op = 1'b1;
          else if (misal) mis = 1'b1;
          else begin
            go_bus  = 1'b1;
            stall_c = 1'b1;
            state_n = S_BUS;
          end
        end
      end
      S_BUS: begin
        if (mem_ack_i) begin
          done    = 1'b1;
          state_n = S_IDLE;
        end else if (cnt == CNT_LAST) begin
          tmo     = 1'b1;
          state_n = S_IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Stall is forced low during reset so every output reads 0 while rst is asserted.
  assign stall_req_o = rst & stall_c;
  assign kill        = flush_q | flush_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      flush_q <= 1'b0;
      addr_q  <= '0;
      sz_q    <= SZ_W;
      uns_q   <= 1'b0;
      st_q    <= 1'b0;
      wreg_q  <= 1'b0;
      wd_q    <= '0;
    end else if (go_bus) begin
      cnt     <= '0;
      flush_q <= 1'b0;
      addr_q  <= mem_addr_i;
      sz_q    <= sz;
      uns_q   <= uns;
      st_q    <= is_st;
      wreg_q  <= wreg_i;
      wd_q    <= wd_i;
    end else if (state == S_BUS) begin
      cnt <= cnt + CW'(1);
      if (flush_i) flush_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_ce_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_sel_o   <= 4'b0000;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
      wb_valid_o  <= 1'b0;
      wd_o        <= '0;
      wreg_o      <= 1'b0;
      wdata_o     <= '0;
      excp_o      <= 1'b0;
      excp_code_o <= 2'b00;
      badaddr_o   <= '0;
    end else begin
      wb_valid_o  <= 1'b0;
      wd_o        <= '0;
      wreg_o      <= 1'b0;
      wdata_o     <= '0;
      excp_o      <= 1'b0;
      excp_code_o <= 2'b00;
      badaddr_o   <= '0;
      if (pass_op) begin
        wb_valid_o <= 1'b1;
        wd_o       <= wd_i;
        wreg_o     <= wreg_i;
        wdata_o    <= wdata_i;
      end
      if (mis) begin
        wb_valid_o  <= 1'b1;
        wd_o        <= wd_i;
        excp_o      <= 1'b1;
        excp_code_o <= is_st ? 2'b10 : 2'b01;
        badaddr_o   <= mem_addr_i;
      end
      if (go_bus) begin
        mem_ce_o   <= 1'b1;
        mem_we_o   <= is_st;
        mem_sel_o  <= sel_c;
        mem_addr_o <= {mem_addr_i[ADDR_W-1:2], 2'b00};
        mem_data_o <= sdata_c;
      end
      if (done || tmo) begin
        mem_ce_o  <= 1'b0;
        mem_we_o  <= 1'b0;
        mem_sel_o <= 4'b0000;
        if (!kill) begin
          wb_valid_o <= 1'b1;
          wd_o       <= wd_q;
          if (done) begin
            wreg_o  <= st_q ? 1'b0 : wreg_q;
            wdata_o <= st_q ? 32'h0 : load_data;
          end else begin
            excp_o      <= 1'b1;
            excp_code_o <= 2'b11;
            badaddr_o   <= addr_q;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed cases plus randomized instructions
// checked against a transaction-level model of loads, stores and exceptions.
module tb_mem_lsu;
  localparam int TO = 4;
  localparam logic [7:0] OP_LB = 8'hE0, OP_LH = 8'hE1, OP_LW = 8'hE3, OP_LBU = 8'hE4,
                         OP_LHU = 8'hE5, OP_SB = 8'hE8, OP_SH = 8'hE9, OP_SW = 8'hEB,
                         OP_ADD = 8'h21;

  logic clk, rst, valid_i, flush_i, wreg_i, mem_ack_i;
  logic [4:0] wd_i, wd_o;
  logic [31:0] wdata_i, reg2_i, mem_addr_i, mem_data_i;
  logic [7:0] aluop_i;
  logic stall_req_o, wb_valid_o, wreg_o, excp_o, mem_we_o, mem_ce_o;
  logic [31:0] wdata_o, badaddr_o, mem_addr_o, mem_data_o;
  logic [1:0] excp_code_o;
  logic [3:0] mem_sel_o;

  mem_lsu #(.ADDR_W(32), .REGADDR_W(5), .ALUOP_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i), .wd_i(wd_i),
    .wreg_i(wreg_i), .wdata_i(wdata_i), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i),
    .reg2_i(reg2_i), .stall_req_o(stall_req_o), .wb_valid_o(wb_valid_o), .wd_o(wd_o),
    .wreg_o(wreg_o), .wdata_o(wdata_o), .excp_o(excp_o), .excp_code_o(excp_code_o),
    .badaddr_o(badaddr_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_sel_o(mem_sel_o), .mem_data_o(mem_data_o), .mem_ce_o(mem_ce_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        chk_data;
    logic        excp;
    logic [1:0]  code;
    logic [31:0] bad;
  } wb_t;
  wb_t expq[$];
  wb_t ce;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---- behavioural model ----
  function automatic int op_size(input logic [7:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction
  function automatic bit op_store(input logic [7:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction
  function automatic bit op_signed(input logic [7:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction
  function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
    int sz = op_size(op);
    longint range = longint'(1) << (8 * sz);
    longint v = (longint'(d) >> (8 * (a % 4))) % range;
    if (op_signed(op) && v >= range / 2) v = v - range;
    return v[31:0];
  endfunction
  function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [31:0] a);
    int sz = op_size(op);
    int s = ((1 << sz) - 1) << (a % 4);
    return s[3:0];
  endfunction
  function automatic logic [31:0] m_sdata(input logic [7:0] op, input logic [31:0] d);
    case (op_size(op))
      1: return (d % 256) * 32'h0101_0101;
      2: return (d % 65536) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // ---- compare process: every cycle, WB outputs vs expected pulses ----
  always @(negedge clk) begin
    if (rst) begin
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        ce = expq.pop_front();
        chk("wb_valid", wb_valid_o, 1);
        chk("wb_wd", wd_o, ce.wd);
        chk("wb_wreg", wreg_o, ce.wreg);
        chk("wb_excp", excp_o, ce.excp);
        if (ce.excp) begin
          chk("wb_code", excp_code_o, ce.code);
          chk("wb_badaddr", badaddr_o, ce.bad);
        end
        if (ce.chk_data) chk("wb_wdata", wdata_o, ce.wdata);
      end else begin
        chk("wb_quiet", {wb_valid_o, excp_o, wreg_o}, 0);
        if (expq.size() > 0 && expq[0].cyc < cyc) begin
          tests++; fails++;
          $display("FAIL wb_missing: expected pulse at cycle %0d not seen", expq[0].cyc);
          void'(expq.pop_front());
        end
      end
    end
  end

  // fl_at: -1 none, 0 flush in the IDLE cycle, n>0 flush in BUS cycle n-1.
  // w: BUS cycle index carrying ack (>= TO means never).
  task automatic run(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                     input logic [31:0] rdata, input logic [31:0] wdv, input logic [4:0] wdst,
                     input logic wr, input int w, input int fl_at);
    wb_t e;
    int sz = op_size(op);
    bit st = op_store(op);
    valid_i = 1'b1; aluop_i = op; mem_addr_i = addr; reg2_i = r2; mem_data_i = rdata;
    wdata_i = wdv; wd_i = wdst; wreg_i = wr; flush_i = (fl_at == 0); mem_ack_i = 1'b0;
    @(negedge clk);
    chk("idle_ce", mem_ce_o, 0);
    chk("idle_we", mem_we_o, 0);
    chk("idle_sel", mem_sel_o, 0);
    e.cyc = cyc + 1; e.wd = wdst; e.wreg = 1'b0; e.wdata = '0; e.chk_data = 1'b0;
    e.excp = 1'b0; e.code = 2'b00; e.bad = addr;
    if (fl_at == 0) begin
      chk("flush_idle_stall", stall_req_o, 0);
    end else if (sz == 0) begin
      chk("alu_stall", stall_req_o, 0);
      e.wreg = wr; e.wdata = wdv; e.chk_data = 1'b1;
      expq.push_back(e);
    end else if (addr % sz != 0) begin
      chk("mis_stall", stall_req_o, 0);
      e.excp = 1'b1; e.code = st ? 2'b10 : 2'b01;
      expq.push_back(e);
    end else begin
      chk("req_stall", stall_req_o, 1);
      @(posedge clk); #1;
      for (int n = 0; n < TO; n++) begin
        mem_ack_i = (n == w);
        flush_i = (fl_at == n + 1);
        @(negedge clk);
        chk("bus_ce", mem_ce_o, 1);
        chk("bus_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
        chk("bus_we", mem_we_o, st);
        chk("bus_sel", mem_sel_o, m_sel(op, addr));
        if (st) chk("bus_data", mem_data_o, m_sdata(op, r2));
        chk("bus_stall", stall_req_o, (n == w || n == TO - 1) ? 0 : 1);
        if (n == w || n == TO - 1) begin
          if (!(fl_at >= 1 && fl_at - 1 <= n)) begin
            e.cyc = cyc + 1;
            if (n == w) begin
              e.wreg = st ? 1'b0 : wr;
              e.wdata = m_load(op, addr, rdata);
              e.chk_data = !st;
            end else begin
              e.excp = 1'b1; e.code = 2'b11;
            end
            expq.push_back(e);
          end
          break;
        end
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    valid_i = 1'b0; flush_i = 1'b0; mem_ack_i = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    valid_i = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_stall"}, stall_req_o, 0);
    chk({nm, "_wbv"}, wb_valid_o, 0);
    chk({nm, "_wd"}, wd_o, 0);
    chk({nm, "_wreg"}, wreg_o, 0);
    chk({nm, "_wdata"}, wdata_o, 0);
    chk({nm, "_excp"}, excp_o, 0);
    chk({nm, "_code"}, excp_code_o, 0);
    chk({nm, "_bad"}, badaddr_o, 0);
    chk({nm, "_maddr"}, mem_addr_o, 0);
    chk({nm, "_we"}, mem_we_o, 0);
    chk({nm, "_sel"}, mem_sel_o, 0);
    chk({nm, "_mdata"}, mem_data_o, 0);
    chk({nm, "_ce"}, mem_ce_o, 0);
  endtask

  logic [7:0] ops [9] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, OP_ADD};

  initial begin
    rst = 1'b0; valid_i = 1'b0; flush_i = 1'b0; wd_i = '0; wreg_i = 1'b0; wdata_i = '0;
    aluop_i = '0; mem_addr_i = '0; reg2_i = '0; mem_data_i = '0; mem_ack_i = 1'b0;
    #12;
    chk_all_zero("reset");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // model pins against hand-computed values
    chk("pin_lw", m_load(OP_LW, 32'h100, 32'hDEADBEEF), 32'hDEADBEEF);
    chk("pin_lb", m_load(OP_LB, 32'h203, 32'h80FF1234), 32'hFFFFFF80);
    chk("pin_lbu", m_load(OP_LBU, 32'h203, 32'h80FF1234), 32'h00000080);
    chk("pin_lh", m_load(OP_LH, 32'h202, 32'h80FF1234), 32'hFFFF80FF);
    chk("pin_sel_b", m_sel(OP_LB, 32'h203), 4'b1000);
    chk("pin_sel_h", m_sel(OP_SH, 32'h302), 4'b1100);
    chk("pin_sh_data", m_sdata(OP_SH, 32'h0000ABCD), 32'hABCDABCD);
    chk("pin_sb_data", m_sdata(OP_SB, 32'h12345678), 32'h78787878);

    run(OP_LW,  32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 5'd3, 1'b1, 3, -1);
    run(OP_LB,  32'h203, 32'h0, 32'h80FF1234, 32'h0, 5'd4, 1'b1, 1, -1);
    run(OP_LBU, 32'h203, 32'h0, 32'h80FF1234, 32'h0, 5'd5, 1'b1, 0, -1);
    run(OP_SH,  32'h302, 32'h0000ABCD, 32'h0, 32'h0, 5'd6, 1'b1, 0, -1);
    run(OP_LW,  32'h101, 32'h0, 32'h0, 32'h0, 5'd7, 1'b1, 0, -1);
    run(OP_SH,  32'h0FF, 32'h1, 32'h0, 32'h0, 5'd8, 1'b0, 0, -1);
    run(OP_SW,  32'h400, 32'h11223344, 32'h0, 32'h0, 5'd9, 1'b0, TO + 1, -1);
    run(OP_SW,  32'h404, 32'h55667788, 32'h0, 32'h0, 5'd9, 1'b0, TO - 1, -1);
    run(OP_ADD, 32'h0, 32'h0, 32'h0, 32'hCAFEF00D, 5'd10, 1'b1, 0, -1);
    run(OP_LW,  32'h500, 32'h0, 32'h12345678, 32'h0, 5'd11, 1'b1, 2, 1);
    run(OP_SW,  32'h504, 32'h0, 32'h0, 32'h0, 5'd12, 1'b0, TO + 1, 2);
    run(OP_LW,  32'h508, 32'h0, 32'h0, 32'h0, 5'd13, 1'b1, 0, 0);
    idle_cycles(2);

    // reset in the middle of a bus cycle
    valid_i = 1'b1; aluop_i = OP_SW; mem_addr_i = 32'h40; reg2_i = 32'hA5A5A5A5;
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1 chk_all_zero("rst_bus");
    valid_i = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 400; i++) begin
      logic [7:0] op;
      logic [31:0] a;
      int sz, w, fl, r;
      op = ops[$urandom_range(0, 8)];
      sz = op_size(op);
      a = $urandom;
      if (sz > 1 && $urandom_range(0, 3) != 0) a = a & ~(sz - 1);
      w = $urandom_range(0, TO + 1);
      r = $urandom_range(0, 9);
      fl = (r < 7) ? -1 : $urandom_range(0, 4);
      run(op, a, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
          1'($urandom_range(0, 1)), w, fl);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
    end
    idle_cycles(3);
    if (expq.size() != 0) begin
      tests++; fails++;
      $display("FAIL wb_leftover: %0d expected pulses never seen", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
